// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/hold control for load-use, jump and memory-wait hazards.
// Define HAZARD_STATS_EN to add saturating stall_cycles and flush_count statistics ports.
module pipeline_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       idex_mem_read,
  input  logic [4:0] idex_rt,
  input  logic       idex_jump,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       ifid_flush,
  output logic       idex_bubble,
  output logic       idex_hold,
  output logic       exmem_hold,
  output logic [1:0] state
`ifdef HAZARD_STATS_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, LOAD_STALL = 2'd1, FLUSH = 2'd2, MEM_WAIT = 2'd3} state_t;
  state_t st, nxt;
  logic luh, memstall, do_stall, do_flush, do_luh;
  assign luh = idex_mem_read && idex_rt != 5'd0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
  assign memstall = mem_req && !mem_ready;
  // MEM_WAIT holds on mem_ready alone; jump and load-use are only honoured from RUN
  assign do_stall = !rst && (st == MEM_WAIT ? !mem_ready : memstall);
  assign do_flush = !rst && st == RUN && !memstall && idex_jump;
  assign do_luh = !rst && st == RUN && !memstall && !idex_jump && luh;
  assign nxt = rst ? RUN : do_stall ? MEM_WAIT : do_flush ? FLUSH : do_luh ? LOAD_STALL : RUN;
  assign pc_write = !rst && !do_stall && !do_luh;
  assign ifid_write = pc_write;
  assign ifid_flush = rst || do_flush;
  assign idex_bubble = rst || do_flush || do_luh;
  assign idex_hold = do_stall;
  assign exmem_hold = do_stall;
  assign state = st;
  always_ff @(posedge clk) begin
    if (rst) st <= RUN;
    else st <= nxt;
  end
`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && stall_cycles != 16'hFFFF) stall_cycles <= stall_cycles + 16'd1;
      if (do_flush && flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table-driven scoreboard bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst, idex_mem_read, idex_jump, mem_req, mem_ready;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold;
  logic [1:0] state;
`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cycles, flush_count;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst), .idex_mem_read(idex_mem_read), .idex_rt(idex_rt),
    .idex_jump(idex_jump), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .mem_req(mem_req), .mem_ready(mem_ready), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .idex_hold(idex_hold), .exmem_hold(exmem_hold), .state(state)
`ifdef HAZARD_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  // eo = {pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold}; es = state before the edge
  typedef struct {
    logic rst, mr;
    logic [4:0] xrt;
    logic jmp;
    logic [4:0] rs, rt;
    logic req, rdy;
    logic [5:0] eo;
    logic [1:0] es;
  } vec_t;
  typedef struct {
    logic [5:0] o;
    logic [1:0] s;
    int id;
  } exp_t;

  vec_t tbl[32];
  exp_t q[$];

  localparam logic [5:0] DEF = 6'b110000, RST = 6'b001100, LUH = 6'b000100,
                         JMP = 6'b111100, MW = 6'b000011;

  function automatic vec_t mk(logic r, logic mr, logic [4:0] xrt, logic j, logic [4:0] rs,
                              logic [4:0] rt, logic req, logic rdy, logic [5:0] eo, logic [1:0] es);
    vec_t v;
    v.rst = r; v.mr = mr; v.xrt = xrt; v.jmp = j; v.rs = rs; v.rt = rt;
    v.req = req; v.rdy = rdy; v.eo = eo; v.es = es;
    return v;
  endfunction

  task automatic check(string name, int id, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic step(vec_t v, int id);
    exp_t e;
    @(negedge clk);
    rst = v.rst; idex_mem_read = v.mr; idex_rt = v.xrt; idex_jump = v.jmp;
    ifid_rs = v.rs; ifid_rt = v.rt; mem_req = v.req; mem_ready = v.rdy;
    q.push_back('{o: v.eo, s: v.es, id: id});
    #2;
    e = q.pop_front();
    check("outputs", e.id, {10'd0, pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_hold}, {10'd0, e.o});
    check("state", e.id, {14'd0, state}, {14'd0, e.s});
  endtask

  initial begin
    vec_t idle, ms, jp, rs1;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
    tbl[0]  = mk(1, 0, 0, 1, 0, 0, 1, 0, RST, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
    tbl[2]  = mk(0, 1, 5, 0, 5, 0, 0, 0, LUH, 0);
    tbl[3]  = mk(0, 1, 5, 0, 5, 0, 0, 0, DEF, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 0, DEF, 0);
    tbl[6]  = mk(0, 1, 7, 0, 3, 7, 0, 0, LUH, 0);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 1);
    tbl[8]  = mk(0, 0, 0, 1, 0, 0, 0, 0, JMP, 0);
    tbl[9]  = mk(0, 0, 0, 1, 0, 0, 0, 0, DEF, 2);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 0, MW, 0);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 1, 0, MW, 3);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 0, MW, 3);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, DEF, 3);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 1, 1, DEF, 0);
    tbl[17] = mk(0, 1, 5, 1, 5, 0, 1, 0, MW, 0);
    tbl[18] = mk(0, 1, 5, 1, 5, 0, 1, 0, MW, 3);
    tbl[19] = mk(0, 1, 5, 1, 5, 0, 1, 1, DEF, 3);
    tbl[20] = mk(0, 1, 5, 1, 5, 0, 0, 0, JMP, 0);
    tbl[21] = mk(0, 1, 5, 0, 5, 0, 0, 0, DEF, 2);
    tbl[22] = mk(0, 1, 5, 0, 5, 0, 0, 0, LUH, 0);
    tbl[23] = mk(0, 0, 0, 0, 0, 0, 1, 0, MW, 1);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 1, 0, MW, 3);
    tbl[25] = mk(1, 0, 0, 0, 0, 0, 1, 0, RST, 3);
    tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, DEF, 0);
    tbl[27] = mk(0, 0, 0, 1, 0, 0, 0, 0, JMP, 0);
    tbl[28] = mk(0, 0, 0, 0, 0, 0, 1, 0, MW, 2);
    tbl[29] = mk(0, 0, 0, 0, 0, 0, 1, 1, DEF, 3);
    tbl[30] = mk(0, 1, 9, 0, 0, 9, 0, 0, LUH, 0);
    tbl[31] = mk(1, 1, 9, 0, 0, 9, 0, 0, RST, 1);
    rst = 1; idex_mem_read = 0; idex_rt = 0; idex_jump = 0;
    ifid_rs = 0; ifid_rt = 0; mem_req = 0; mem_ready = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++) step(tbl[i], i);
    step(idle, 100);
    ms = mk(0, 0, 0, 0, 0, 0, 1, 0, MW, 0);
    jp = mk(0, 0, 0, 1, 0, 0, 0, 0, JMP, 0);
    rs1 = mk(1, 0, 0, 0, 0, 0, 1, 0, RST, 3);
`ifdef HAZARD_STATS_EN
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, RST, 0), 200);
    step(idle, 201);
    check("stall_cycles_reset", 201, stall_cycles, 16'd0);
    check("flush_count_reset", 201, flush_count, 16'd0);
    step(ms, 202);
    ms.es = 3;
    step(ms, 203);
    step(ms, 204);
    step(mk(0, 0, 0, 0, 0, 0, 1, 1, DEF, 3), 205);
    step(idle, 206);
    check("stall_cycles_memwait", 206, stall_cycles, 16'd3);
    step(jp, 207);
    idle.es = 2;
    step(idle, 208);
    check("flush_count_jump", 208, flush_count, 16'd1);
    check("stall_cycles_jump", 208, stall_cycles, 16'd3);
    ms.es = 0;
    step(ms, 209);
    repeat (70000) @(posedge clk);
    @(negedge clk); #2;
    check("stall_cycles_sat", 209, stall_cycles, 16'hFFFF);
    check("state_sat", 209, {14'd0, state}, 16'd3);
    step(rs1, 210);
    idle.es = 0;
    step(idle, 211);
    check("stall_cycles_rst_mw", 211, stall_cycles, 16'd0);
    check("flush_count_rst_mw", 211, flush_count, 16'd0);
`else
    step(ms, 300);
    step(rs1, 301);
    step(idle, 302);
    step(jp, 303);
    idle.es = 2;
    step(idle, 304);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL use one clock, and reset SHALL be synchronous and active-high.
REQ-002 clk  in  1  rising-edge clock shared with all pipeline registers.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 idex_mem_read  in  1  mem_read control currently held in the ID/EX register.
REQ-005 idex_rt  in  5  rt field currently held in ID/EX.
REQ-006 idex_jump  in  1  jump control currently held in ID/EX.
REQ-007 ifid_rs, ifid_rt  in  5 each  source register fields of the instruction in decode.
REQ-008 mem_req  in  1  EX/MEM stage has a data-memory access this cycle.
REQ-009 mem_ready  in  1  data memory completes the pending access this cycle.
REQ-010 pc_write  out  1  PC load enable.
REQ-011 ifid_write  out  1  IF/ID load enable.
REQ-012 ifid_flush  out  1  IF/ID loads a NOP.
REQ-013 idex_bubble  out  1  ID/EX loads all control fields as zero.
REQ-014 idex_hold, exmem_hold  out  1 each  ID/EX and EX/MEM keep their current contents.
REQ-015 state  out  2  current FSM state code.

Function
REQ-016 FSM states SHALL be RUN=0, LOAD_STALL=1, FLUSH=2 and MEM_WAIT=3, held in a 2-bit register.
REQ-017 Outputs SHALL be combinational from the state register and the current inputs, so each takes effect at the same edge as the hazard it covers.
REQ-018 Default outputs, when no condition below applies, SHALL be: pc_write=1, ifid_write=1, all other outputs 0.
REQ-019 luh (load-use hazard) SHALL be: idex_mem_read AND idex_rt!=0 AND (idex_rt==ifid_rs OR idex_rt==ifid_rt).
REQ-020 memstall SHALL be: mem_req AND NOT mem_ready.
REQ-021 Within each state, conditions SHALL be evaluated in priority order memstall > idex_jump > luh.
REQ-022 RUN with memstall: outputs pc_write=0, ifid_write=0, idex_hold=1, exmem_hold=1; next state MEM_WAIT.
REQ-023 RUN with idex_jump (no memstall): outputs ifid_flush=1, idex_bubble=1, pc_write=1; next state FLUSH.
REQ-024 RUN with luh only: outputs pc_write=0, ifid_write=0, idex_bubble=1; next state LOAD_STALL; total stall is exactly 1 cycle.
REQ-025 LOAD_STALL and FLUSH: luh and idex_jump SHALL be ignored; memstall SHALL be handled as in RUN (next state MEM_WAIT); otherwise default outputs; next state RUN.
REQ-026 MEM_WAIT: hold outputs as in REQ-022 while mem_ready=0.
REQ-027 MEM_WAIT, first cycle with mem_ready=1: default outputs, next state RUN; a jump or load-use hazard pending at that point SHALL be serviced on the following cycle in RUN.
REQ-028 mem_ready=1 in the same RUN cycle as mem_req SHALL not stall.

Reset
REQ-029 While rst=1, outputs SHALL be: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, holds 0; all other inputs are ignored.
REQ-030 The first edge with rst=1 SHALL set state=RUN, including when asserted in the middle of a MEM_WAIT or LOAD_STALL sequence.
REQ-031 Statistics counters, if present, SHALL clear to 0 on reset.

Configuration
REQ-032 The macro HAZARD_STATS_EN SHALL control the statistics feature.
REQ-033 With HAZARD_STATS_EN defined, the block SHALL add two ports: stall_cycles (out, 16) counts non-reset cycles with pc_write=0, and flush_count (out, 16) counts REQ-023 events.
REQ-034 Both counters SHALL saturate at 0xFFFF.
REQ-035 With HAZARD_STATS_EN undefined, the ports and logic SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Load-use: idex_mem_read=1, idex_rt=5, ifid_rs=5 -> one cycle with pc_write=0 and idex_bubble=1, state 0->1->0; repeating the case with idex_rt=0 -> no stall.
REQ-037 Jump: idex_jump=1 in RUN -> ifid_flush=1 and idex_bubble=1 for one cycle, state 2 next; idex_jump held high in FLUSH -> no second flush.
REQ-038 Memory wait: mem_req=1 with mem_ready low for 3 cycles -> pc_write=0 and exmem_hold=1 for 3 cycles, state 3, then back to RUN; with stats enabled, stall_cycles=3.
REQ-039 Simultaneous events: memstall, jump and luh all true -> MEM_WAIT first; jump serviced in the cycle after mem_ready (per REQ-027).
REQ-040 Reset mid-MEM_WAIT -> state=0 after the edge, ifid_flush=1 and idex_bubble=1 during reset, counters 0.
REQ-041 Saturation: force 70000 stall cycles -> stall_cycles=0xFFFF with no wrap.
